// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// default geometry/latency and the address-error rule.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEFAULT_DEPTH_WORDS = 64;
  localparam int DEFAULT_WAIT_STATES = 2;
  localparam int WORD_LSB            = 2;

  // Misaligned, or beyond the last byte of the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[WORD_LSB-1:0] != '0) || (addr >= 32'(depth_words * 4));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write with enable, combinational read by index.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: storage has no reset; contents must survive rst_n and a reset
  // port would also stop the array mapping onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory with a fixed number of wait states: accepts one
// request at a time, responds with a one-cycle pulse and freezes the pipe.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        accept;
  logic        src_write;
  logic [31:0] src_addr;
  logic [31:0] src_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        cap_err;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // NOTE: every signal gets its default before the case so no path leaves
  // one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // With no wait states RESP is entered on the accept edge itself, before
  // the capture registers hold the request, so the write takes the live inputs.
  assign src_write = (state_q == IDLE) ? req_write : write_q;
  assign src_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign src_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign mem_we    = rst_n && (state_d == RESP) && (state_q != RESP) && src_write
                     && !addr_err(src_addr, DEPTH_WORDS);

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (src_addr[IDX_W+WORD_LSB-1:WORD_LSB]),
    .wdata (src_wdata),
    .raddr (addr_q[IDX_W+WORD_LSB-1:WORD_LSB]),
    .rdata (mem_rdata)
  );

  assign cap_err   = addr_err(addr_q, DEPTH_WORDS);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && cap_err;
  assign rsp_rdata = (rsp_valid && !write_q && !cap_err) ? mem_rdata : '0;
  assign stall     = rst_n && req_valid && (state_q != RESP);

endmodule
